// File: rtl/alu_pkg.sv
// Shared definitions for the alu_mdu execution unit: opcodes, FSM states,
// result flag encodings and small opcode-decoding helpers.
package alu_pkg;

    // Base ALU operations
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    // Multiply group
    localparam logic [3:0] ALU_MUL    = 4'd8;
    localparam logic [3:0] ALU_MULH   = 4'd9;
    localparam logic [3:0] ALU_MULHSU = 4'd10;
    localparam logic [3:0] ALU_MULHU  = 4'd11;
    // Divide group
    localparam logic [3:0] ALU_DIV    = 4'd12;
    localparam logic [3:0] ALU_DIVU   = 4'd13;
    localparam logic [3:0] ALU_REM    = 4'd14;
    localparam logic [3:0] ALU_REMU   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] FLAG_ZERO = 2'b00;
    localparam logic [1:0] FLAG_NEG  = 2'b01;
    localparam logic [1:0] FLAG_POS  = 2'b10;

    // Opcodes 8..15 are handled by the iterative multiply/divide datapath.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3];
    endfunction

    // Within the mul/div group, bit 2 selects the divide half.
    function automatic logic is_div(input logic [3:0] op);
        return op[3] & op[2];
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / restoring-divide datapath, one bit per cycle.
// Operands are converted to magnitudes at start; the sign of the result is
// latched and applied on the final iteration, where `done` pulses and
// `result` carries the sign-corrected value for the parent to register.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    // hi_q: product high half / partial remainder
    // lo_q: multiplier being consumed / dividend shifting into quotient
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             hi_sel_q, hi_sel_d;

    logic             signed_a_s, signed_b_s;
    logic             sign_a_s, sign_b_s;
    logic [XLEN-1:0]  mag_a_s, mag_b_s;
    logic             neg_s, hi_sel_s;

    logic [XLEN:0]    mul_sum_s;
    logic [XLEN:0]    div_shift_s;
    logic [XLEN-1:0]  div_diff_s;
    logic             div_ge_s;
    logic [XLEN-1:0]  hi_step_s, lo_step_s;

    logic [2*XLEN-1:0] full_s, full_neg_s, full_fix_s;
    logic [XLEN-1:0]   div_pick_s;

    // Decode operand signedness, result sign and which half is returned.
    always_comb begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
        hi_sel_s   = 1'b0;
        case (op)
            ALU_MUL:    begin signed_a_s = 1'b1; signed_b_s = 1'b1; hi_sel_s = 1'b0; end
            ALU_MULH:   begin signed_a_s = 1'b1; signed_b_s = 1'b1; hi_sel_s = 1'b1; end
            ALU_MULHSU: begin signed_a_s = 1'b1; signed_b_s = 1'b0; hi_sel_s = 1'b1; end
            ALU_MULHU:  begin signed_a_s = 1'b0; signed_b_s = 1'b0; hi_sel_s = 1'b1; end
            ALU_DIV:    begin signed_a_s = 1'b1; signed_b_s = 1'b1; hi_sel_s = 1'b0; end
            ALU_DIVU:   begin signed_a_s = 1'b0; signed_b_s = 1'b0; hi_sel_s = 1'b0; end
            ALU_REM:    begin signed_a_s = 1'b1; signed_b_s = 1'b1; hi_sel_s = 1'b1; end
            ALU_REMU:   begin signed_a_s = 1'b0; signed_b_s = 1'b0; hi_sel_s = 1'b1; end
            default:    begin signed_a_s = 1'b0; signed_b_s = 1'b0; hi_sel_s = 1'b0; end
        endcase
        sign_a_s = signed_a_s & a[XLEN-1];
        sign_b_s = signed_b_s & b[XLEN-1];
        mag_a_s  = sign_a_s ? (~a + XLEN'(1)) : a;
        mag_b_s  = sign_b_s ? (~b + XLEN'(1)) : b;
        // Remainder follows the dividend; everything else is sign(A)^sign(B).
        if ((op == ALU_REM) || (op == ALU_REMU)) begin
            neg_s = sign_a_s;
        end else begin
            neg_s = sign_a_s ^ sign_b_s;
        end
    end

    // One shift-add or one restoring-subtract step on the shared registers.
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_q, lo_q[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
        // The true difference is below the divisor, so XLEN bits suffice.
        div_diff_s  = div_shift_s[XLEN-1:0] - opnd_q;
        if (div_q) begin
            hi_step_s = div_ge_s ? div_diff_s : div_shift_s[XLEN-1:0];
            lo_step_s = {lo_q[XLEN-2:0], div_ge_s};
        end else begin
            hi_step_s = mul_sum_s[XLEN:1];
            lo_step_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
        end
    end

    // Load operands on start, iterate while the counter is nonzero.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        neg_d    = neg_q;
        hi_sel_d = hi_sel_q;
        if (flush) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (start) begin
            div_d    = is_div(op);
            neg_d    = neg_s;
            hi_sel_d = hi_sel_s;
            hi_d     = {XLEN{1'b0}};
            cnt_d    = CNT_W'(XLEN);
            if (is_div(op)) begin
                lo_d   = mag_a_s;
                opnd_d = mag_b_s;
            end else begin
                lo_d   = mag_b_s;
                opnd_d = mag_a_s;
            end
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            hi_d  = hi_step_s;
            lo_d  = lo_step_s;
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Sign-correct the final step's value and select the requested half.
    always_comb begin
        full_s     = {hi_step_s, lo_step_s};
        full_neg_s = ~full_s + (2*XLEN)'(1);
        full_fix_s = neg_q ? full_neg_s : full_s;
        div_pick_s = hi_sel_q ? hi_step_s : lo_step_s;
        if (div_q) begin
            result = neg_q ? (~div_pick_s + XLEN'(1)) : div_pick_s;
        end else begin
            result = hi_sel_q ? full_fix_s[2*XLEN-1:XLEN] : full_fix_s[XLEN-1:0];
        end
    end

    assign done = (cnt_q == CNT_W'(1));

    // Datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            opnd_q   <= {XLEN{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            hi_sel_q <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            hi_sel_q <= hi_sel_d;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execution unit: single-cycle base ALU ops plus iterative RV32M-style
// multiply/divide, with valid/ready handshakes on both sides.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN),
    parameter int OP_W    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] C,
    output logic [1:0]      f,
    output logic            busy
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_e          state_q, state_d;
    logic [XLEN-1:0] c_q, c_d;
    logic [1:0]      f_q, f_d;
    logic            out_valid_q, out_valid_d;

    logic [3:0]        op_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic              in_ready_s, accept_s;
    logic [XLEN-1:0]   base_res_s;
    logic              div_special_s;
    logic [XLEN-1:0]   div_special_res_s;
    state_e            launch_state_s;
    logic [XLEN-1:0]   launch_c_s;
    logic              launch_iter_s;
    logic              start_s;
    logic              iter_done_s;
    logic [XLEN-1:0]   iter_result_s;

    function automatic logic [1:0] flag_of(input logic [XLEN-1:0] v);
        if (v == {XLEN{1'b0}}) begin
            return FLAG_ZERO;
        end else if (v[XLEN-1]) begin
            return FLAG_NEG;
        end else begin
            return FLAG_POS;
        end
    endfunction

    assign op_s       = op[3:0];
    assign shamt_s    = B[SHAMT_W-1:0];
    assign in_ready_s = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept_s   = in_valid & in_ready_s;

    // Single-cycle base operations.
    always_comb begin
        base_res_s = {XLEN{1'b0}};
        case (op_s)
            ALU_ADD: base_res_s = A + B;
            ALU_SUB: base_res_s = A - B;
            ALU_AND: base_res_s = A & B;
            ALU_OR:  base_res_s = A | B;
            ALU_XOR: base_res_s = A ^ B;
            ALU_SLL: base_res_s = A << shamt_s;
            ALU_SRL: base_res_s = A >> shamt_s;
            ALU_SRA: base_res_s = $unsigned($signed(A) >>> shamt_s);
            default: base_res_s = {XLEN{1'b0}};
        endcase
    end

    // Divide corner cases that skip iteration: divide-by-zero and signed overflow.
    always_comb begin
        div_special_s     = 1'b0;
        div_special_res_s = A;
        if (B == {XLEN{1'b0}}) begin
            div_special_s     = 1'b1;
            div_special_res_s = ((op_s == ALU_DIV) || (op_s == ALU_DIVU)) ? ALL_ONES : A;
        end else if (((op_s == ALU_DIV) || (op_s == ALU_REM)) && (A == MOST_NEG) && (B == ALL_ONES)) begin
            div_special_s     = 1'b1;
            div_special_res_s = (op_s == ALU_DIV) ? A : {XLEN{1'b0}};
        end else begin
            div_special_s     = 1'b0;
            div_special_res_s = A;
        end
    end

    // Decide where an accepted request goes: straight to DONE or into iteration.
    always_comb begin
        launch_state_s = ST_DONE;
        launch_c_s     = base_res_s;
        launch_iter_s  = 1'b0;
        if (!is_muldiv(op_s)) begin
            launch_c_s = base_res_s;
        end else if (is_div(op_s) && div_special_s) begin
            launch_c_s = div_special_res_s;
        end else begin
            launch_iter_s  = 1'b1;
            launch_c_s     = c_q;
            launch_state_s = is_div(op_s) ? ST_DIV : ST_MUL;
        end
    end

    // FSM next state and output register updates; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        start_s     = 1'b0;
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_d     = launch_state_s;
                        c_d         = launch_c_s;
                        out_valid_d = ~launch_iter_s;
                        start_s     = launch_iter_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (iter_done_s) begin
                        state_d     = ST_DONE;
                        c_d         = iter_result_s;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DONE: begin
                    if (accept_s) begin
                        state_d     = launch_state_s;
                        c_d         = launch_c_s;
                        out_valid_d = ~launch_iter_s;
                        start_s     = launch_iter_s;
                    end else if (out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
        f_d = flag_of(c_d);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            c_q         <= {XLEN{1'b0}};
            f_q         <= FLAG_ZERO;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
        end
    end

    alu_muldiv_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .start  (start_s),
        .op     (op_s),
        .a      (A),
        .b      (B),
        .done   (iter_done_s),
        .result (iter_result_s)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign C         = c_q;
    assign f         = f_q;
    assign busy      = (state_q == ST_MUL) | (state_q == ST_DIV);

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: requests push a model result into a queue,
// a monitor pops and compares every retired result.
module tb_alu_mdu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]      op;
    logic [XLEN-1:0] A, B, C;
    logic [1:0]      f;

    int n_cmp = 0;
    int n_err = 0;
    logic [XLEN-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .C(C), .f(f), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: RISC-V arithmetic on 64-bit integers.
    function automatic logic [31:0] ref_c(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic signed [31:0] as32;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        as32 = a;
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[4:0];
            4'd6:  return a >> b[4:0];
            4'd7:  return as32 >>> b[4:0];
            4'd8:  begin p = sa * sb; return p[31:0]; end
            4'd9:  begin p = sa * sb; return p[63:32]; end
            4'd10: begin p = sa * ub; return p[63:32]; end
            4'd11: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            4'd12: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            4'd13: begin if (b == 32'h0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            4'd14: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            4'd15: begin if (b == 32'h0) return a; p = ua % ub; return p[31:0]; end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] ref_f(input logic [31:0] c);
        if (c == 32'h0) return 2'b00;
        if ($signed(c) < 0) return 2'b01;
        return 2'b10;
    endfunction

    // Monitor: every retired result is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got C=%h with empty scoreboard (t=%0t)", C, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("result_C", {32'h0, C}, {32'h0, e});
                check("result_f", {62'h0, f}, {62'h0, ref_f(e)});
            end
        end
    end

    // Issue one request starting at posedge+1; returns at posedge+1 after accept.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit rnd);
        int waited;
        waited = 0;
        op = o; A = a; B = b; in_valid = 1'b1;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
            @(posedge clk); #1;
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(ref_c(o, a, b));
            @(posedge clk); #1;
            in_valid = 1'b0;
            op = 4'($urandom); A = $urandom; B = $urandom;
        end
    endtask

    // Wait for out_valid (out_ready held high) and check latency, busy and value.
    task automatic wait_lat(input string name, input int exp_lat, input bit chk_busy, input logic [31:0] exp_c);
        int lat;
        bit busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && chk_busy && !busy) busy_ok = 1'b0;
        end while (!out_valid && lat < 200);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_C"}, {32'h0, C}, {32'h0, exp_c});
        check({name, "_busy_at_done"}, {63'h0, busy}, 64'h0);
        if (chk_busy) check({name, "_busy_during"}, {63'h0, busy_ok}, 64'h1);
        @(posedge clk); #1;
    endtask

    logic [3:0]  d_op [13] = '{4'd0, 4'd1, 4'd7, 4'd6, 4'd9, 4'd11, 4'd8, 4'd12, 4'd14, 4'd13, 4'd15, 4'd12, 4'd14};
    logic [31:0] d_a  [13] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'h80000000};
    logic [31:0] d_b  [13] = '{32'd1, 32'd5, 32'h24, 32'h24, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_c  [13] = '{32'h80000000, 32'h0, 32'hF8000000, 32'h08000000, 32'hFFFFFFFF, 32'h00000001,
                               32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'h0};
    int          d_lat[13] = '{1, 1, 1, 1, 33, 33, 33, 33, 33, 1, 1, 1, 1};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; op = 4'd0; A = 32'd1; B = 32'd1;   // request during reset: ignored
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {63'h0, out_valid}, 64'h0);
        check("reset_C", {32'h0, C}, 64'h0);
        check("reset_f", {62'h0, f}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {63'h0, out_valid}, 64'h0);
        @(posedge clk); #1;

        // Directed table from the test plan
        for (int i = 0; i < 13; i++) begin
            issue(d_op[i], d_a[i], d_b[i], 1'b0);
            wait_lat($sformatf("dir%0d", i), d_lat[i], d_lat[i] > 1, d_c[i]);
        end

        // Stall in DONE, then back-to-back accept on release
        out_ready = 1'b0;
        issue(4'd0, 32'h12345678, 32'h11111111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", {63'h0, out_valid}, 64'h1);
            check("stall_C", {32'h0, C}, 64'h23456789);
            check("stall_f", {62'h0, f}, 64'h2);
            check("stall_in_ready", {63'h0, in_ready}, 64'h0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(4'd0, 32'd40, 32'd2, 1'b0);
        wait_lat("b2b_add", 1, 1'b0, 32'd42);

        // Reset in the middle of a DIV
        issue(4'd12, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_out_valid", {63'h0, out_valid}, 64'h0);
        check("midreset_busy", {63'h0, busy}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(4'd0, 32'd2, 32'd3, 1'b0);
        wait_lat("add_after_reset", 1, 1'b0, 32'd5);

        // Flush at cycle 5 of a MUL
        issue(4'd8, 32'd123, 32'd456, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {63'h0, busy}, 64'h0);
        check("flush_out_valid", {63'h0, out_valid}, 64'h0);
        check("flush_in_ready", {63'h0, in_ready}, 64'h1);
        repeat (40) @(posedge clk);
        #1;

        // Flush wins over a simultaneous accept
        op = 4'd0; A = 32'd9; B = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_drop_out_valid", {63'h0, out_valid}, 64'h0);
        check("flush_drop_busy", {63'h0, busy}, 64'h0);
        @(posedge clk); #1;

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            int sel;
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'h0;
            else if (sel == 1) rb = 32'hFFFFFFFF;
            else if (sel == 2) ra = 32'h80000000;
            else if (sel == 3) rb = 32'($urandom_range(1, 9));
            issue(ro, ra, rb, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
